code_lock_ctrl: RTL and testbench

CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

---
 rtl/code_lock_ctrl_if.sv | 27 ++
 rtl/code_lock_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/code_lock_ctrl_if.sv
// Signal bundle for the code lock: digit entry handshake, user requests and status.
// The master side drives digits and requests; the slave side is the lock controller.
interface code_lock_ctrl_if;
    // Handshake: a digit transfers on a rising clk edge where digit_vld and digit_rdy
    // are both high. The master may assert digit_vld regardless of digit_rdy; digits
    // offered while digit_rdy is low are dropped, never queued.
    logic [3:0] digit;
    logic       digit_vld;
    logic       prog;
    logic       lock;
    logic       digit_rdy;
    logic       unlocked;
    logic       error;
    logic       lockout;
    logic [1:0] fail_cnt;
    logic [2:0] dbg_state;

    modport master (
        output digit, digit_vld, prog, lock,
        input  digit_rdy, unlocked, error, lockout, fail_cnt, dbg_state
    );

    modport slave (
        input  digit, digit_vld, prog, lock,
        output digit_rdy, unlocked, error, lockout, fail_cnt, dbg_state
    );
endinterface

// File: rtl/code_lock_ctrl.sv
// Four-digit code lock: checks entered digits against a stored code, opens on a match,
// counts failures into a timed lockout, and allows reprogramming while open.
module code_lock_ctrl #(
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned MAX_FAIL       = 3,
    parameter logic [15:0] RST_CODE       = 16'h1234
) (
    input  logic             clk,
    input  logic             rst,
    code_lock_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_LOCKED  = 3'd0,
        S_ENTRY   = 3'd1,
        S_OPEN    = 3'd2,
        S_PROG    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_e;

    localparam logic [7:0] LOCKOUT_LOAD = 8'(LOCKOUT_CYCLES);
    localparam logic [1:0] FAIL_LIMIT   = 2'(MAX_FAIL);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        mm_q, mm_d;
    logic [1:0]  fail_cnt_q, fail_cnt_d;
    logic [7:0]  lo_cnt_q, lo_cnt_d;
    logic [15:0] code_q, code_d;
    logic        unlocked_q, unlocked_d;
    logic        error_q, error_d;
    logic        lockout_q, lockout_d;
    logic        digit_rdy_q, digit_rdy_d;

    logic        accept;
    logic [3:0]  cur_digit;
    logic        digit_ne;
    logic        attempt_bad;
    logic [1:0]  fail_next;

    // digit0 sits in the top nibble, so idx counts down through the code word
    always_comb begin
        cur_digit = code_q[15:12];
        case (idx_q)
            2'd0: cur_digit = code_q[15:12];
            2'd1: cur_digit = code_q[11:8];
            2'd2: cur_digit = code_q[7:4];
            2'd3: cur_digit = code_q[3:0];
            default: cur_digit = code_q[15:12];
        endcase
    end

    always_comb begin
        accept      = bus.digit_vld && digit_rdy_q;
        digit_ne    = (bus.digit != cur_digit);
        attempt_bad = mm_q || digit_ne;
        fail_next   = (fail_cnt_q == FAIL_LIMIT) ? fail_cnt_q : fail_cnt_q + 2'd1;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mm_d       = mm_q;
        fail_cnt_d = fail_cnt_q;
        lo_cnt_d   = lo_cnt_q;
        code_d     = code_q;
        error_d    = 1'b0;

        case (state_q)
            S_LOCKED: begin
                if (accept) begin
                    idx_d   = 2'd1;
                    mm_d    = digit_ne;
                    state_d = S_ENTRY;
                end
            end

            S_ENTRY: begin
                if (accept) begin
                    if (idx_q != 2'd3) begin
                        mm_d  = attempt_bad;
                        idx_d = idx_q + 2'd1;
                    end else begin
                        idx_d = 2'd0;
                        mm_d  = 1'b0;
                        if (attempt_bad) begin
                            error_d    = 1'b1;
                            fail_cnt_d = fail_next;
                            if (fail_next == FAIL_LIMIT) begin
                                state_d  = S_LOCKOUT;
                                lo_cnt_d = LOCKOUT_LOAD;
                            end else begin
                                state_d = S_LOCKED;
                            end
                        end else begin
                            fail_cnt_d = 2'd0;
                            state_d    = S_OPEN;
                        end
                    end
                end
            end

            S_OPEN: begin
                // prog outranks lock when both arrive together
                if (bus.prog) begin
                    state_d = S_PROG;
                    idx_d   = 2'd0;
                end else if (bus.lock) begin
                    state_d = S_LOCKED;
                    idx_d   = 2'd0;
                    mm_d    = 1'b0;
                end
            end

            S_PROG: begin
                if (accept) begin
                    case (idx_q)
                        2'd0: code_d[15:12] = bus.digit;
                        2'd1: code_d[11:8]  = bus.digit;
                        2'd2: code_d[7:4]   = bus.digit;
                        2'd3: code_d[3:0]   = bus.digit;
                        default: code_d = code_q;
                    endcase
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = S_LOCKED;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            S_LOCKOUT: begin
                if (lo_cnt_q <= 8'd1) begin
                    lo_cnt_d   = 8'd0;
                    fail_cnt_d = 2'd0;
                    state_d    = S_LOCKED;
                end else begin
                    lo_cnt_d = lo_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = S_LOCKED;
                idx_d   = 2'd0;
                mm_d    = 1'b0;
            end
        endcase

        // Status flags are registered from the next state so they line up with it
        unlocked_d  = (state_d == S_OPEN);
        lockout_d   = (state_d == S_LOCKOUT);
        digit_rdy_d = (state_d == S_LOCKED) || (state_d == S_ENTRY) || (state_d == S_PROG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOCKED;
            idx_q       <= 2'd0;
            mm_q        <= 1'b0;
            fail_cnt_q  <= 2'd0;
            lo_cnt_q    <= 8'd0;
            code_q      <= RST_CODE;
            unlocked_q  <= 1'b0;
            error_q     <= 1'b0;
            lockout_q   <= 1'b0;
            digit_rdy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mm_q        <= mm_d;
            fail_cnt_q  <= fail_cnt_d;
            lo_cnt_q    <= lo_cnt_d;
            code_q      <= code_d;
            unlocked_q  <= unlocked_d;
            error_q     <= error_d;
            lockout_q   <= lockout_d;
            digit_rdy_q <= digit_rdy_d;
        end
    end

    assign bus.digit_rdy = digit_rdy_q;
    assign bus.unlocked  = unlocked_q;
    assign bus.error     = error_q;
    assign bus.lockout   = lockout_q;
    assign bus.fail_cnt  = fail_cnt_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl: unlock, failures, lockout timing, reprogramming
// and reset in the middle of entry and programming.
module tb_code_lock_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    code_lock_ctrl_if bus ();

    code_lock_ctrl #(
        .LOCKOUT_CYCLES(16),
        .MAX_FAIL      (3),
        .RST_CODE      (16'h1234)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_unl, input logic e_err,
                             input logic e_lko, input logic e_rdy, input logic [1:0] e_fail);
        chk_bit({tag, ".unlocked"},  bus.unlocked,  e_unl);
        chk_bit({tag, ".error"},     bus.error,     e_err);
        chk_bit({tag, ".lockout"},   bus.lockout,   e_lko);
        chk_bit({tag, ".digit_rdy"}, bus.digit_rdy, e_rdy);
        chk_cnt({tag, ".fail_cnt"},  bus.fail_cnt,  e_fail);
    endtask

    // One digit per cycle; returns on the falling edge after the last accepting edge
    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            bus.digit     = c[15 - 4*i -: 4];
            bus.digit_vld = 1'b1;
            @(negedge clk);
            if (i < 3) chk_bit("no_early_error", bus.error, 1'b0);
        end
        bus.digit_vld = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_req(input logic p, input logic l);
        bus.prog = p;
        bus.lock = l;
        @(negedge clk);
        bus.prog = 1'b0;
        bus.lock = 1'b0;
    endtask

    initial begin
        bus.digit     = 4'd0;
        bus.digit_vld = 1'b0;
        bus.prog      = 1'b0;
        bus.lock      = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);

        enter_code(16'h1234);
        check_all("open_1234", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        bus.digit     = 4'd1;
        bus.digit_vld = 1'b1;
        repeat (3) @(negedge clk);
        bus.digit_vld = 1'b0;
        check_all("open_ignores_vld", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        pulse_req(1'b0, 1'b1);
        check_all("relock", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);

        enter_code(16'h1235);
        check_all("bad_1235", 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
        @(negedge clk);
        chk_bit("error_one_cycle", bus.error, 1'b0);

        enter_code(16'h9999);
        check_all("bad_second", 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        @(negedge clk);
        enter_code(16'h9999);
        check_all("bad_third", 1'b0, 1'b1, 1'b1, 1'b0, 2'd3);

        // Correct digits offered throughout lockout must be dropped
        bus.digit     = 4'd1;
        bus.digit_vld = 1'b1;
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            check_all($sformatf("lockout_cyc%0d", k), 1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
        end
        @(negedge clk);
        bus.digit_vld = 1'b0;
        check_all("lockout_done", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);

        enter_code(16'h1234);
        check_all("open_after_lockout", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        pulse_req(1'b1, 1'b0);
        check_all("prog_entered", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        enter_code(16'h9876);
        check_all("prog_done", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);

        enter_code(16'h1234);
        check_all("old_code_rejected", 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
        enter_code(16'h9876);
        check_all("new_code_open", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        pulse_req(1'b1, 1'b1);
        check_all("prog_wins", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        bus.digit     = 4'd5;
        bus.digit_vld = 1'b1;
        repeat (2) @(negedge clk);
        bus.digit_vld = 1'b0;
        pulse_rst();
        check_all("rst_in_prog", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        enter_code(16'h1234);
        check_all("code_restored", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        pulse_req(1'b0, 1'b1);
        bus.digit     = 4'd1;
        bus.digit_vld = 1'b1;
        @(negedge clk);
        bus.digit     = 4'd2;
        @(negedge clk);
        bus.digit_vld = 1'b0;
        pulse_rst();
        enter_code(16'h1234);
        check_all("rst_mid_entry", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        pulse_req(1'b0, 1'b1);
        enter_code(16'h9999);
        chk_cnt("fail_before_rst", bus.fail_cnt, 2'd1);
        pulse_rst();
        check_all("rst_clears_fail", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
